// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU request arbiter: ALU control codes,
// ALUOp encodings, the legal control range and the sequencer states.
package alu_arb_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_NOP   = 3'b000;
  localparam logic [3:0] CTRL_MAX    = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  // Codes above SLTU have no ALU meaning and are answered with an error.
  function automatic logic ctrl_legal(input logic [3:0] ctrl);
    return (ctrl <= CTRL_MAX);
  endfunction

  // Only add and subtract produce a meaningful carry/borrow.
  function automatic logic ctrl_has_carry(input logic [3:0] ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_arbiter.sv
// Combinational request arbiter. Default build: round-robin starting
// just after last_grant. With ALU_ARB_FIXED_PRIO_EN defined: fixed
// priority, lowest index wins, last_grant ignored.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  // Scan downwards so the lowest requesting index is the last one written.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx   = IDX_W'(i);
        grant_valid = 1'b1;
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end
`else
  int               idx;
  logic [IDX_W-1:0] sel;

  // Walk from the farthest candidate (last_grant itself) to the nearest
  // (last_grant+1) so the nearest requester after last_grant wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IDX_W'(idx);
      if (req[sel]) begin
        grant_idx   = sel;
        grant_valid = 1'b1;
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end
`endif

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one external alu_32bit between NUM_REQ valid/ready requesters.
// Operands are registered in front of the ALU and result/flags behind it.
// Arbitration mode is selected by ALU_ARB_FIXED_PRIO_EN (see rr_arbiter).
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | arbitrate; req_ready to winner, accept and latch operands
//   ST_EXEC | drive ALU with R-type op, capture result/flags at edge
//   ST_RESP | hold response to owner until its rsp_ready
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_b,
  input  logic [NUM_REQ-1:0][CTRL_W-1:0]  req_ctrl,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [DATA_W-1:0]               rsp_result,
  output logic [3:0]                      rsp_flags,
  output logic                            rsp_err,
  output logic [2:0]                      alu_op,
  output logic [CTRL_W-1:0]               alu_ctrl,
  output logic [DATA_W-1:0]               alu_a,
  output logic [DATA_W-1:0]               alu_b,
  input  logic [DATA_W-1:0]               alu_result,
  input  logic                            alu_n,
  input  logic                            alu_z,
  input  logic                            alu_c,
  input  logic                            alu_v
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q;
  logic [IDX_W-1:0]    owner_q;
  logic [DATA_W-1:0]   opa_q, opb_q;
  logic [CTRL_W-1:0]   ctrl_q;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic                accept;
  logic                rsp_done;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign accept   = (state_q == ST_IDLE) && arb_valid;
  assign rsp_done = (state_q == ST_RESP) && rsp_ready[owner_q];

  assign alu_a    = opa_q;
  assign alu_b    = opb_q;
  assign alu_ctrl = ctrl_q;

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, request accept and ALUOp decode.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    alu_op    = ALUOP_NOP;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = arb_grant;
        if (arb_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_op  = ALUOP_RTYPE;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture on accept; owner index kept for the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      ctrl_q  <= '0;
      owner_q <= '0;
    end else if (accept) begin
      opa_q   <= req_a[arb_idx];
      opb_q   <= req_b[arb_idx];
      ctrl_q  <= req_ctrl[arb_idx];
      owner_q <= arb_idx;
    end
  end

  // Round-robin pointer advances only when the response is consumed.
  always_ff @(posedge clk) begin
    if (rst)           last_grant_q <= LAST_RST;
    else if (rsp_done) last_grant_q <= owner_q;
  end

  // Result/flag capture behind the ALU and response valid to the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      rsp_valid  <= '0;
    end else if (state_q == ST_EXEC) begin
      if (!ctrl_legal(ctrl_q)) begin
        rsp_result <= '0;
        rsp_flags  <= '0;
        rsp_err    <= 1'b1;
      end else begin
        rsp_result <= alu_result;
        rsp_flags  <= {alu_n, alu_z, alu_c & ctrl_has_carry(ctrl_q), alu_v};
        rsp_err    <= 1'b0;
      end
      rsp_valid <= NUM_REQ'(1) << owner_q;
    end else if (rsp_done) begin
      rsp_valid <= '0;
    end
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares one alu_32bit instance between NUM_REQ requesters, e.g. the core execute stage and an address-generation or debug unit. Each requester uses a valid/ready request channel and a valid/ready response channel. Requesters are granted round-robin and the block sequences IDLE → EXEC → RESP. Operands are registered in front of the ALU and the result/flags are registered behind it, so the ALU's combinational path is isolated from both requesters.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 32, operand/result width; must stay 32 to match the ALU.
- CTRL_W, 4, ALU control code width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accept.
- req_a  in  NUM_REQ×32  operand A per requester.
- req_b  in  NUM_REQ×32  operand B per requester.
- req_ctrl  in  NUM_REQ×4  ALU control code per requester.
- rsp_valid  out  NUM_REQ  response valid, one-hot to the owning requester.
- rsp_ready  in  NUM_REQ  response accept.
- rsp_result  out  32  registered ALU result (shared bus).
- rsp_flags  out  4  registered {N,Z,C,V}.
- rsp_err  out  1  illegal control code flag.
- alu_op  out  3  ALUOp to ALU.
- alu_ctrl  out  4  ALUControl to ALU.
- alu_a  out  32  operand A to ALU.
- alu_b  out  32  operand B to ALU.
- alu_result  in  32  ALU result.
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flags.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - state = IDLE.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - req_ready = 0, rsp_valid = 0.
  - rsp_result = 0, rsp_flags = 0, rsp_err = 0.
  - Operand registers = 0, alu_op = 3'b000, alu_ctrl = 0.
- IDLE:
  - The grant index g is the first i with req_valid[i]=1, scanning from last_grant+1 with wrap-around.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0.
  - The handshake fires in the same cycle. The block latches req_a[g], req_b[g], req_ctrl[g] and g, then moves to EXEC.
  - No valid requester: stay in IDLE.
- EXEC (1 cycle):
  - alu_op = 3'b010 (R-type); alu_ctrl, alu_a, alu_b come from the registers.
  - At the clock edge, capture alu_result and the flags into the rsp registers, then move to RESP.
  - C is captured only for ctrl ADD (0000) or SUB (0001); otherwise C is stored as 0.
  - ctrl > 4'b1001 is illegal: result = 0, flags = 0, rsp_err = 1.
  - Outside EXEC, alu_op = 3'b000.
- RESP:
  - rsp_valid[g]=1. rsp_result, rsp_flags and rsp_err are held stable until rsp_ready[g]=1.
  - On that handshake: last_grant ← g, rsp_valid ← 0, move to IDLE.
  - All req_ready bits are 0 during EXEC and RESP.
- Timing: request accepted at cycle T → rsp_valid at T+2. Minimum spacing between accepts is 3 cycles. Only one transaction is outstanding.
- Requester obligations: hold req_valid and the request data stable until req_ready. A requester that drops req_valid before acceptance is simply not granted.
- Reset mid-transaction: the transaction is discarded, no response is issued, and last_grant returns to NUM_REQ-1.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; last_grant is unused.
- Undefined (default): round-robin as described above.
- Latency and handshakes are identical in both modes.

Decomposition:
- Package alu_arb_pkg:
  - ALU control enum (ADD..SLTU), shared with alu_32bit.
  - ALUOP_RTYPE = 3'b010, ALUOP_NOP = 3'b000.
  - CTRL_MAX = 4'b1001.
  - State enum {IDLE, EXEC, RESP}.
- Sub-module rr_arbiter:
  - Combinational.
  - Inputs: req vector, last_grant. Outputs: one-hot grant and index.
  - Holds the ALU_ARB_FIXED_PRIO_EN switch.

Test Plan:
- req0 ADD, a=5, b=7, rsp_ready tied 1 → req_ready[0] at T, rsp_valid[0] at T+2, rsp_result=12, flags N=0 Z=1'b0 C=0.
- req0 and req1 both held valid after reset, 6 transactions → grant order 0,1,0,1,0,1. With ALU_ARB_FIXED_PRIO_EN defined → 0,0,0,… while req0 is held.
- req1 SUB, a=0, b=1 → rsp_result=32'hFFFFFFFF, N=1, Z=0, C=1; only rsp_valid[1] asserted.
- Backpressure: rsp_ready[0]=0 for 5 cycles with req1 valid → rsp_valid[0], result and flags stable; req_ready[1] stays 0; req1 granted the cycle after rsp_ready[0] rises and the block returns to IDLE.
- req0 ctrl=4'b1100 → rsp_err=1, rsp_result=0, rsp_flags=0. The next legal request clears rsp_err.
- rst pulsed while in EXEC → next cycle all outputs at reset values and no rsp_valid. A subsequent simultaneous req0/req1 grants req0 first.
